// File: rtl/i2c_master_arbiter.sv
// Two-requester round-robin arbiter in front of a single I2C master FSM.
// Optional transaction watchdog enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_master_arbiter #(
    parameter int ADDR_W         = 7,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic              i2c_core_clk_i,
    input  logic              reset_i,
    input  logic [1:0]        req_i,
    input  logic              rw0_i,
    input  logic              rw1_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [ADDR_W-1:0] addr1_i,
    output logic [1:0]        grant_o,
    output logic [1:0]        done_o,
    output logic              err_o,
    output logic              enable_o,
    output logic              rw_o,
    output logic [ADDR_W-1:0] addr_o,
    input  logic              master_busy_i,
    input  logic              master_done_i,
    input  logic              ack_err_i
);

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        ISSUE,
        BUSY,
        RELEASE
    } state_t;

    state_t state;
    logic   last_served;
    logic   win;
    logic   timed_out;

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wd_cnt;
    assign timed_out = (wd_cnt == CNT_W'(TIMEOUT_CYCLES));
`else
    assign timed_out = 1'b0;
`endif

    // On a tie the requester that was not served last wins.
    always_comb begin
        // NOTE: default first so every path assigns win and no latch is inferred.
        win = 1'b0;
        case (req_i)
            2'b01:   win = 1'b0;
            2'b10:   win = 1'b1;
            2'b11:   win = ~last_served;
            default: win = 1'b0;
        endcase
    end

    // NOTE: all state and outputs update with <= so every register sees pre-edge values.
    always_ff @(posedge i2c_core_clk_i) begin
        if (reset_i) begin
            state       <= IDLE;
            last_served <= 1'b1;
            grant_o     <= '0;
            done_o      <= '0;
            err_o       <= 1'b0;
            enable_o    <= 1'b0;
            rw_o        <= 1'b0;
            addr_o      <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
            wd_cnt      <= '0;
`endif
        end else begin
            done_o <= '0;
            case (state)
                IDLE: begin
                    if (|req_i) state <= GRANT;
                end
                GRANT: begin
                    if (|req_i) begin
                        grant_o  <= win ? 2'b10 : 2'b01;
                        rw_o     <= win ? rw1_i : rw0_i;
                        addr_o   <= win ? addr1_i : addr0_i;
                        enable_o <= 1'b1;
                        state    <= ISSUE;
`ifdef I2C_ARB_TIMEOUT_EN
                        wd_cnt   <= '0;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                ISSUE: begin
`ifdef I2C_ARB_TIMEOUT_EN
                    wd_cnt <= wd_cnt + 1'b1;
`endif
                    if (timed_out) begin
                        err_o    <= 1'b1;
                        enable_o <= 1'b0;
                        done_o   <= grant_o;
                        state    <= RELEASE;
                    end else if (master_busy_i) begin
                        state <= BUSY;
                    end
                end
                BUSY: begin
`ifdef I2C_ARB_TIMEOUT_EN
                    wd_cnt <= wd_cnt + 1'b1;
`endif
                    // A real completion takes priority over a coincident timeout.
                    if (master_done_i) begin
                        err_o    <= ack_err_i;
                        enable_o <= 1'b0;
                        done_o   <= grant_o;
                        state    <= RELEASE;
                    end else if (timed_out) begin
                        err_o    <= 1'b1;
                        enable_o <= 1'b0;
                        done_o   <= grant_o;
                        state    <= RELEASE;
                    end
                end
                RELEASE: begin
                    last_served <= grant_o[1];
                    grant_o     <= '0;
                    err_o       <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Scoreboard bench for i2c_master_arbiter: randomized transactions against a
// round-robin reference model; honours I2C_ARB_TIMEOUT_EN when defined.
module tb_i2c_master_arbiter;

    localparam int ADDR_W = 7;
`ifdef I2C_ARB_TIMEOUT_EN
    localparam int TMO       = 15;
    localparam int DIR_BUSY  = 8;
    localparam int MAX_BUSY  = 8;
`else
    localparam int TMO       = 1023;
    localparam int DIR_BUSY  = 20;
    localparam int MAX_BUSY  = 25;
`endif

    logic              clk = 1'b0;
    logic              reset_i = 1'b1;
    logic [1:0]        req_i = '0;
    logic              rw0_i = 1'b0;
    logic              rw1_i = 1'b0;
    logic [ADDR_W-1:0] addr0_i = '0;
    logic [ADDR_W-1:0] addr1_i = '0;
    logic [1:0]        grant_o;
    logic [1:0]        done_o;
    logic              err_o;
    logic              enable_o;
    logic              rw_o;
    logic [ADDR_W-1:0] addr_o;
    logic              master_busy_i = 1'b0;
    logic              master_done_i = 1'b0;
    logic              ack_err_i = 1'b0;

    i2c_master_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)) dut (
        .i2c_core_clk_i(clk),
        .reset_i       (reset_i),
        .req_i         (req_i),
        .rw0_i         (rw0_i),
        .rw1_i         (rw1_i),
        .addr0_i       (addr0_i),
        .addr1_i       (addr1_i),
        .grant_o       (grant_o),
        .done_o        (done_o),
        .err_o         (err_o),
        .enable_o      (enable_o),
        .rw_o          (rw_o),
        .addr_o        (addr_o),
        .master_busy_i (master_busy_i),
        .master_done_i (master_done_i),
        .ack_err_i     (ack_err_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]        grant;
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic              err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   last_done_cyc = 0;
    bit   gap_valid = 1'b0;
    logic prev_en = 1'b0;
    logic model_last = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares DUT completions against the scoreboard queue.
    always @(negedge clk) begin
        if (enable_o && !prev_en) begin
            if (gap_valid) check("enable_gap", cyc - last_done_cyc, 3);
            if (sb.size() > 0) begin
                check("issue_grant", grant_o, sb[0].grant);
                check("issue_addr", addr_o, sb[0].addr);
                check("issue_rw", rw_o, sb[0].rw);
            end
        end
        if (done_o != 2'b00) begin
            if (sb.size() == 0) begin
                check("unexpected_done", done_o, 2'b00);
            end else begin
                mon_e = sb.pop_front();
                check("done", done_o, mon_e.grant);
                check("done_err", err_o, mon_e.err);
                check("done_addr", addr_o, mon_e.addr);
                check("done_rw", rw_o, mon_e.rw);
                check("done_grant", grant_o, mon_e.grant);
                check("done_enable", enable_o, 1'b0);
            end
            last_done_cyc = cyc;
            gap_valid = 1'b1;
        end
        prev_en = enable_o;
    end

    // Reference model: a lone request wins, a tie goes to whoever was not served last.
    task automatic model_push(input logic [1:0] req, input logic r0, input logic r1,
                              input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                              input logic e);
        logic [1:0] g;
        if (req == 2'b11) g = (model_last == 1'b1) ? 2'b01 : 2'b10;
        else              g = req;
        model_last = (g == 2'b10);
        sb.push_back('{g, (g == 2'b10) ? r1 : r0, (g == 2'b10) ? a1 : a0, e});
    endtask

    task automatic wait_enable(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (enable_o) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("enable_timeout", 0, 1);
    endtask

    task automatic run_round(input logic [1:0] req, input logic r0, input logic r1,
                             input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                             input int d, input int n, input logic e,
                             input bit spur, input bit perturb, input logic [ADDR_W-1:0] new_a0,
                             input bit drop);
        bit seen;
        logic [1:0] g;
        req_i = req; rw0_i = r0; rw1_i = r1; addr0_i = a0; addr1_i = a1;
        model_push(req, r0, r1, a0, a1, e);
        g = sb[sb.size()-1].grant;
        wait_enable(seen);
        if (!seen) begin
            void'(sb.pop_back());
            return;
        end
        for (int k = 1; k <= d; k++) begin
            @(negedge clk);
            master_done_i = spur && (k == 1);
            ack_err_i     = spur && (k == 1);
            master_busy_i = (k == d);
        end
        for (int j = 1; j <= n; j++) begin
            @(negedge clk);
            if (j == 1 && perturb) begin
                addr0_i = new_a0; addr1_i = ~a1; rw0_i = ~r0; rw1_i = ~r1;
            end
            if (j == 1 && drop) req_i = req & ~g;
            master_done_i = (j == n);
            ack_err_i     = (j == n) ? e : 1'b0;
        end
        @(negedge clk);
        master_done_i = 1'b0; ack_err_i = 1'b0; master_busy_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (done_o != 2'b00) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) begin
            check("done_timeout", 0, 1);
            void'(sb.pop_front());
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"}, grant_o, 0);
        check({tag, "_done"}, done_o, 0);
        check({tag, "_err"}, err_o, 0);
        check({tag, "_enable"}, enable_o, 0);
        check({tag, "_rw"}, rw_o, 0);
        check({tag, "_addr"}, addr_o, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit seen;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset_i = 1'b0;
        @(negedge clk);

        // Tie held across three transactions from reset: 01, 10, 01.
        for (int t = 0; t < 3; t++)
            run_round(2'b11, 1'b0, 1'b1, 7'h3C, 7'h41, 2, 4, 1'b0, 1'b0, 1'b0, 7'h00, 1'b0);

        // Read from 0x50, address input changed during BUSY.
        run_round(2'b01, 1'b1, 1'b0, 7'h50, 7'h11, 3, DIR_BUSY, 1'b0, 1'b0, 1'b1, 7'h22, 1'b0);

        // NACK from the slave on requester 1, with a stray master_done before BUSY.
        run_round(2'b10, 1'b0, 1'b0, 7'h12, 7'h6E, 3, 5, 1'b1, 1'b1, 1'b0, 7'h00, 1'b0);

        // Reset pulsed while BUSY: everything clears and no done follows.
        req_i = 2'b01; rw0_i = 1'b1; addr0_i = 7'h5A;
        wait_enable(seen);
        @(negedge clk); master_busy_i = 1'b1;
        repeat (3) @(negedge clk);
        reset_i = 1'b1; req_i = 2'b00; master_busy_i = 1'b0;
        @(negedge clk);
        reset_i = 1'b0;
        gap_valid = 1'b0;
        model_last = 1'b1;
        check_all_zero("mid_reset");
        repeat (6) @(negedge clk);
        check("post_reset_enable", enable_o, 0);

`ifdef I2C_ARB_TIMEOUT_EN
        // Master never goes busy: watchdog releases with an error.
        begin
            int lat;
            req_i = 2'b01; rw0_i = 1'b0; addr0_i = 7'h2B;
            model_push(2'b01, 1'b0, 1'b0, 7'h2B, 7'h00, 1'b1);
            wait_enable(seen);
            lat = 0;
            while (done_o == 2'b00 && lat < 40) begin
                @(negedge clk);
                lat++;
            end
            check("timeout_latency", lat, 16);
        end
`endif

        for (int r = 0; r < 40; r++) begin
            run_round(2'($urandom_range(1, 3)), 1'($urandom), 1'($urandom),
                      ADDR_W'($urandom), ADDR_W'($urandom),
                      $urandom_range(1, 4), $urandom_range(1, MAX_BUSY), 1'($urandom),
                      1'($urandom), 1'($urandom), ADDR_W'($urandom), 1'($urandom));
        end

        req_i = 2'b00;
        repeat (8) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/i2c_master_arbiter.md
I2C_MASTER_ARBITER -- requirements
Module: i2c_master_arbiter

Interface
REQ-001 Parameter ADDR_W, default 7: slave address width in bits.
REQ-002 Parameter TIMEOUT_CYCLES, default 1023: watchdog limit in core clocks; used only with I2C_ARB_TIMEOUT_EN.
REQ-003 i2c_core_clk_i  input  1  i2c core clock; all logic is on its rising edge.
REQ-004 reset_i  input  1  reset, synchronous and active-high.
REQ-005 req_i  input  2  per-requester transaction request, level; held until that requester's done_o.
REQ-006 rw0_i, rw1_i  input  1 each  requester direction; 1 = read, 0 = write.
REQ-007 addr0_i, addr1_i  input  ADDR_W each  requester slave address.
REQ-008 grant_o  output  2  one-hot owner of the master; 0 when idle.
REQ-009 done_o  output  2  one-cycle completion pulse to the owner.
REQ-010 err_o  output  1  valid with done_o; 1 = slave NACK or timeout.
REQ-011 enable_o  output  1  enable to the I2C master FSM.
REQ-012 rw_o  output  1  direction to the master FSM.
REQ-013 addr_o  output  ADDR_W  slave address to the master FSM.
REQ-014 master_busy_i  input  1  master FSM is in a transaction.
REQ-015 master_done_i  input  1  one-cycle pulse: master FSM reached STOP.
REQ-016 ack_err_i  input  1  NACK flag from master, sampled with master_done_i.

Function
REQ-017 States: IDLE, GRANT, ISSUE, BUSY, RELEASE; one-hot or binary encoding.
REQ-018 IDLE: if req_i != 0, go to GRANT next cycle; else stay. grant_o = 0, enable_o = 0.
REQ-019 GRANT: select winner with round-robin; latch winner's rw and addr into rw_o and addr_o; assert the matching grant_o bit; go to ISSUE.
REQ-020 Round-robin: a single request wins; if both request, the one not served last wins; last_served = 1 after reset, so requester 0 wins the first tie.
REQ-021 ISSUE: enable_o = 1; go to BUSY when master_busy_i = 1.
REQ-022 BUSY: enable_o = 1; on master_done_i = 1, capture ack_err_i and go to RELEASE.
REQ-023 RELEASE: enable_o = 0; done_o[owner] = 1 and err_o = captured error for exactly this cycle; update last_served; clear grant_o; go to IDLE.
REQ-024 Minimum gap between done_o and the next enable_o rise is 2 cycles (IDLE, GRANT).
REQ-025 rw_o and addr_o are stable from GRANT through RELEASE; requester input changes during this time are ignored.
REQ-026 If a requester drops req_i before done_o, the transaction still completes and done_o still pulses.
REQ-027 If req_i is still high in the cycle after done_o, it is a new request and arbitrates normally.
REQ-028 master_done_i outside BUSY is ignored.
REQ-029 grant_o is always one-hot or zero, and done_o always equals grant_o masked to RELEASE.

Reset
REQ-030 While reset_i = 1 at a clock edge, the state goes to IDLE and every output is 0: grant_o, done_o, err_o, enable_o, rw_o, addr_o.
REQ-031 Reset also sets last_served = 1, clears the captured error, and clears the watchdog counter.
REQ-032 Reset mid-transaction drops enable_o at the next edge and produces no done_o pulse.

Configuration
REQ-033 Macro I2C_ARB_TIMEOUT_EN.
- Defined: a counter clears on entering ISSUE and increments each cycle in ISSUE and BUSY. When it reaches TIMEOUT_CYCLES, the FSM goes to RELEASE with err_o = 1.
- Not defined: no counter exists, and ISSUE and BUSY wait indefinitely.

Verification
REQ-034 Scenario: req_i = 01, rw0_i = 1, addr0_i = 7'h50; master_busy_i rises 3 cycles after enable_o; master_done_i pulses 20 cycles later with ack_err_i = 0.
- Response: grant_o = 01, addr_o = 7'h50, rw_o = 1, done_o = 01 with err_o = 0, enable_o low in RELEASE.
REQ-035 Scenario: req_i = 11 held through three transactions.
- Response: grants are 01, then 10, then 01.
REQ-036 Scenario: req_i = 10 with ack_err_i = 1 at master_done_i.
- Response: done_o = 10 with err_o = 1.
REQ-037 Scenario: reset_i pulsed for one cycle while in BUSY.
- Response: next cycle all outputs are 0 and the state is IDLE; no done_o pulse.
REQ-038 Scenario: I2C_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES = 15, master_busy_i never asserted.
- Response: done_o pulses with err_o = 1 at 16 cycles after ISSUE entry.
REQ-039 Scenario: addr0_i changed from 7'h50 to 7'h22 while in BUSY.
- Response: addr_o stays 7'h50 until RELEASE.
